// File: rtl/dsi_line_packetizer.sv
// rtl/dsi_line_packetizer.sv - DSI long-packet builder: header, FIFO payload, CRC-16 footer, 2-entry output buffer.
module dsi_line_packetizer #(
    parameter logic [1:0]  VC_DEFAULT = 2'd0,
    parameter logic [15:0] MAX_WC     = 16'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic [15:0] cfg_wc,
    input  logic [5:0]  cfg_dt,
    input  logic [1:0]  cfg_vc,
    input  logic        cfg_vc_ovr,
    input  logic [31:0] fifo_rd_data,
    input  logic        fifo_rd_empty,
    output logic        fifo_rd_en,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        line_done
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_CRC, S_DONE} state_t;

    // Buffer entry layout: {last, keep[3:0], data[31:0]}
    localparam int EW = 37;

    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [31:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int b = 0; b < 4; b++) begin
            c = c ^ {8'h00, data[8*b +: 8]};
            for (int i = 0; i < 8; i++) begin
                c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
            end
        end
        return c;
    endfunction

    // Each mask selects the header bits covered by one parity bit P0..P5.
    function automatic logic [7:0] dsi_ecc(input logic [23:0] h);
        return {2'b00,
                ^(h & 24'hEFFC00), ^(h & 24'hDF03F0), ^(h & 24'hB8E38E),
                ^(h & 24'h749A6D), ^(h & 24'hF2555B), ^(h & 24'hF12CB7)};
    endfunction

    state_t          state_q, state_d;
    logic [15:0]     wc_q, wc_d;
    logic [7:0]      di_q, di_d;
    logic [13:0]     words_left_q, words_left_d;
    logic            inflight_q, inflight_d;
    logic [15:0]     crc_q, crc_d;
    logic [1:0]      occ_q, occ_d;
    logic [EW-1:0]   ent0_q, ent0_d;
    logic [EW-1:0]   ent1_q, ent1_d;
    logic            busy_q, busy_d;
    logic            line_done_q, line_done_d;

    logic            pop;
    logic [1:0]      occ_free;
    logic            push;
    logic [EW-1:0]   push_ent;
    logic            rd_en;
    logic [15:0]     wc_clamp;

    always_comb begin
        state_d      = state_q;
        wc_d         = wc_q;
        di_d         = di_q;
        words_left_d = words_left_q;
        crc_d        = crc_q;
        busy_d       = busy_q & ~line_done_q;
        line_done_d  = 1'b0;
        push         = 1'b0;
        push_ent     = '0;
        rd_en        = 1'b0;

        pop      = (occ_q != 2'd0) && out_ready;
        occ_free = occ_q - {1'b0, pop};
        wc_clamp = (cfg_wc > MAX_WC) ? MAX_WC : cfg_wc;

        case (state_q)
            S_IDLE: begin
                if (line_start && !busy_q) begin
                    wc_d         = {wc_clamp[15:2], 2'b00};
                    di_d         = {(cfg_vc_ovr ? cfg_vc : VC_DEFAULT), cfg_dt};
                    words_left_d = wc_clamp[15:2];
                    busy_d       = 1'b1;
                    state_d      = S_HDR;
                end
            end
            S_HDR: begin
                push     = 1'b1;
                push_ent = {1'b0, 4'hF, dsi_ecc({wc_q, di_q}), wc_q, di_q};
                state_d  = (words_left_q != 14'd0) ? S_PAY : S_CRC;
            end
            S_PAY: begin
                // Credit counts the word still in flight from the FIFO and frees the slot popped this cycle.
                rd_en = !fifo_rd_empty && (words_left_q != 14'd0) &&
                        ((occ_free + {1'b0, inflight_q}) < 2'd2);
                if (rd_en) begin
                    words_left_d = words_left_q - 14'd1;
                end
                if (inflight_q) begin
                    push     = 1'b1;
                    push_ent = {1'b0, 4'hF, fifo_rd_data};
                    crc_d    = crc16_word(crc_q, fifo_rd_data);
                end
                // Any in-flight word lands this cycle, so the footer can follow without a bubble.
                if (words_left_q == 14'd0) begin
                    state_d = S_CRC;
                end
            end
            S_CRC: begin
                if (occ_free != 2'd2) begin
                    push     = 1'b1;
                    push_ent = {1'b1, 4'b0011, 16'h0000, crc_q};
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (pop && occ_q == 2'd1) begin
                    line_done_d = 1'b1;
                    crc_d       = 16'hFFFF;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        inflight_d = rd_en;

        ent0_d = ent0_q;
        ent1_d = ent1_q;
        if (pop) begin
            ent0_d = ent1_q;
        end
        if (push) begin
            if (occ_free == 2'd0) begin
                ent0_d = push_ent;
            end else begin
                ent1_d = push_ent;
            end
        end
        occ_d = occ_free + {1'b0, push};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wc_q         <= '0;
            di_q         <= '0;
            words_left_q <= '0;
            inflight_q   <= 1'b0;
            crc_q        <= 16'hFFFF;
            occ_q        <= '0;
            ent0_q       <= '0;
            ent1_q       <= '0;
            busy_q       <= 1'b0;
            line_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wc_q         <= wc_d;
            di_q         <= di_d;
            words_left_q <= words_left_d;
            inflight_q   <= inflight_d;
            crc_q        <= crc_d;
            occ_q        <= occ_d;
            ent0_q       <= ent0_d;
            ent1_q       <= ent1_d;
            busy_q       <= busy_d;
            line_done_q  <= line_done_d;
        end
    end

    assign fifo_rd_en = rd_en;
    assign out_valid  = (occ_q != 2'd0);
    assign out_data   = ent0_q[31:0];
    assign out_keep   = ent0_q[35:32];
    assign out_last   = ent0_q[36];
    assign busy       = busy_q;
    assign line_done  = line_done_q;

endmodule

// File: doc/dsi_line_packetizer.md
Name: dsi_line_packetizer

Overview:
- Downstream consumer of the 256x32b synchronous pixel FIFO in the MIPI DSI colorbar path.
- On each line_start it emits a DSI long packet on a 32-bit valid/ready stream toward the lane distributor: one header word, cfg_wc/4 payload words read from the FIFO, then one CRC-16 footer word.
- Drives the FIFO read side directly, accounting for the FIFO's 1-cycle read latency (unregistered output), and absorbs downstream backpressure in a 2-entry output buffer.

Parameters:
- VC_DEFAULT, 2'd0, virtual channel used when cfg_vc_ovr=0
- MAX_WC, 16'd4096, largest legal cfg_wc in bytes; larger values are clamped to MAX_WC

Ports:
- clk  in  1  single clock; FIFO rd_clk is the same clock
- rst_n  in  1  asynchronous active-low reset
- line_start  in  1  1-cycle pulse requesting one packet
- cfg_wc  in  16  payload byte count; bits [1:0] ignored (forced 0)
- cfg_dt  in  6  DSI data type (e.g. 6'h3E RGB888)
- cfg_vc  in  2  virtual channel override value
- cfg_vc_ovr  in  1  1 selects cfg_vc, 0 selects VC_DEFAULT
- fifo_rd_data  in  32  FIFO read data, valid the cycle after fifo_rd_en
- fifo_rd_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO read enable
- out_data  out  32  packet word, byte 0 in [7:0] is transmitted first
- out_keep  out  4  valid byte lanes
- out_last  out  1  marks the footer word
- out_valid  out  1  word valid
- out_ready  in  1  downstream accepts when out_valid&out_ready
- busy  out  1  packet in progress
- line_done  out  1  1-cycle pulse when the footer is accepted

Behaviour:
- Reset values: all outputs 0; state IDLE; CRC register 16'hFFFF; output buffer empty.
- IDLE -> HDR on line_start. cfg_* are latched on the same cycle. busy goes high the next cycle and stays high until the cycle after line_done.
- line_start while busy=1 is ignored; there is no queueing.
- HDR (1 cycle): push header word {ECC[7:0], WC[15:8], WC[7:0], DI}, keep=4'hF.
  - DI = {VC, DT}.
  - ECC[5:0] is the DSI Hamming code over header bits [23:0]; ECC[7:6]=0.
  - Next state is PAY if words_left=cfg_wc[15:2]>0, else CRC.
- PAY:
  - Assert fifo_rd_en when fifo_rd_empty=0, words_left>0 and (buf_occ + rd_inflight) < 2.
  - rd_inflight is fifo_rd_en registered.
  - Push fifo_rd_data into the buffer the cycle after each read, keep=4'hF.
  - Update CRC over the 4 bytes, byte 0 first.
  - Decrement words_left on each fifo_rd_en.
  - When words_left=0 and rd_inflight=0, go to CRC.
  - An empty FIFO mid-line stalls with no read and no error. out_valid may drop between words.
- CRC:
  - When the buffer has space, push {16'h0, crc[15:0]}, keep=4'b0011, last=1.
  - CRC is CRC-16-CCITT, polynomial x^16+x^12+x^5+1, reflected/LSB-first, seed FFFF, no final XOR.
  - Then go to DONE.
- DONE: wait until the buffer is empty and the footer has been accepted. Pulse line_done, reset CRC to FFFF, go to IDLE.
- Output buffer:
  - 2-entry FIFO; out_* reflect the head entry, out_valid = (occ != 0).
  - Push and pop in the same cycle is allowed.
  - A push never occurs when occ=2; the credit rule guarantees this.
  - out_data/keep/last are held stable while out_valid=1 and out_ready=0.
- Throughput: with the FIFO non-empty and out_ready=1, one word per cycle and no bubbles after the header.
- Latency: line_start at cycle T gives the header on out_* at T+2 and the first payload word at T+4 at the earliest.
- cfg_wc > MAX_WC is clamped before the header is formed; the header carries the clamped value.
- Reset mid-packet aborts immediately:
  - buffer is flushed, no line_done is generated;
  - FIFO words already read are discarded;
  - words left in the FIFO are the owner's responsibility.

Test Plan:
1. cfg_wc=16, DT=3E, VC=0, FIFO preloaded with 32'h03020100, 07060504, 0B0A0908, 0F0E0D0C, out_ready=1 -> 6 words: header with bytes 3E,10,00,ECC; the 4 payload words in order; footer keep=0011 with CRC equal to the golden model; line_done on the cycle after footer acceptance; exactly 4 fifo_rd_en pulses.
2. cfg_wc=0 -> header {ECC,00,00,DI}, then footer 16'hFFFF with last=1; fifo_rd_en never asserted.
3. Same as test 1 but out_ready toggled 1,0,0,1 and held low for 10 cycles mid-payload -> no word lost, duplicated or changed while stalled; fifo_rd_en never causes occ>2.
4. FIFO empty after 2 of 4 words, refilled 20 cycles later -> busy stays 1, output resumes with words 3 and 4, CRC correct.
5. Second line_start while busy -> ignored, exactly one packet emitted; line_start on the cycle after line_done -> new packet accepted.
6. rst_n low during PAY -> all outputs 0 within the same cycle, no line_done; a following line_start with cfg_wc=8 -> correct 4-word packet with CRC reseeded from FFFF.
